// File: rtl/pattern_sequencer.sv
// pattern_sequencer: row-based note/speed sequencer feeding the tracker voice.
// Optional build macro SEQ_LOOP_EN: replay from row 0 after last_row instead of returning to idle.
package tracker_pkg;
  typedef enum logic [1:0] {INSTR_SIN, INSTR_SQUARE, INSTR_SAW, INSTR_RAND} instr_tp;
  localparam logic [3:0] MAXVOLUME = 4'hF;
  typedef struct packed {
    instr_tp    instrument;
    logic [3:0] volume;
  } note_tp;
endpackage

module pattern_sequencer
  import tracker_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int TICKW = 16,
  parameter int AW    = $clog2(ROWS)
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  note_tp           wr_note,
  input  logic [3:0]       wr_speed,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [TICKW-1:0] tempo,
  input  logic [AW-1:0]    last_row,
  output note_tp           note,
  output logic [3:0]       speed,
  output logic [AW-1:0]    row,
  output logic             row_strobe,
  output logic             playing,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  typedef struct packed {
    note_tp     note;
    logic [3:0] speed;
  } row_tp;

  localparam note_tp SILENT = '{instrument: INSTR_SIN, volume: 4'd0};

  row_tp            mem [ROWS];
  state_t           state, state_n;
  logic [TICKW-1:0] tick, tick_n, tick_max;
  logic [AW-1:0]    row_n, row_nxt, load_addr;
  note_tp           note_n;
  logic [3:0]       speed_n;
  logic             row_strobe_n, playing_n, done_n;
  logic             load;

  // Pattern storage has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= '{note: wr_note, speed: wr_speed};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick       <= '0;
      row        <= '0;
      note       <= SILENT;
      speed      <= '0;
      row_strobe <= 1'b0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      tick       <= tick_n;
      row        <= row_n;
      note       <= note_n;
      speed      <= speed_n;
      row_strobe <= row_strobe_n;
      playing    <= playing_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    tick_n       = tick;
    row_n        = row;
    note_n       = note;
    speed_n      = speed;
    row_strobe_n = 1'b0;
    playing_n    = playing;
    done_n       = 1'b0;
    load         = 1'b0;
    load_addr    = '0;
    tick_max     = (tempo == '0) ? '0 : tempo - TICKW'(1);
    row_nxt      = row + AW'(1);

    case (state)
      IDLE: begin
        if (start && !stop && !pause) begin
          state_n   = PLAY;
          tick_n    = '0;
          playing_n = 1'b1;
          load      = 1'b1;
        end
      end
      PLAY, PAUSE: begin
        if (stop) begin
          state_n   = IDLE;
          tick_n    = '0;
          row_n     = '0;
          note_n    = SILENT;
          speed_n   = '0;
          playing_n = 1'b0;
        end else if (pause) begin
          state_n = PAUSE;
        end else begin
          // Leaving PAUSE counts as a play cycle, so each paused cycle adds exactly one.
          state_n = PLAY;
          if (tick >= tick_max) begin
            tick_n = '0;
            if (row != last_row) begin
              load      = 1'b1;
              load_addr = row_nxt;
            end else begin
`ifdef SEQ_LOOP_EN
              load = 1'b1;
`else
              state_n   = IDLE;
              row_n     = '0;
              note_n    = SILENT;
              speed_n   = '0;
              playing_n = 1'b0;
              done_n    = 1'b1;
`endif
            end
          end else begin
            tick_n = tick + TICKW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // mem still holds pre-write contents here, so a same-cycle write is seen next visit.
    if (load) begin
      row_n        = load_addr;
      note_n       = mem[load_addr].note;
      speed_n      = mem[load_addr].speed;
      row_strobe_n = 1'b1;
    end
  end

endmodule
